// File: rtl/mote_engine_sequencer.sv
// mote_engine_sequencer
//   Feeds samples into a windowed statistics engine (average / std dev).
//   After a flush it counts samples until the engine window is full. Each
//   accepted sample is tagged, and the tag travels alongside the engine's
//   fixed latency. Only results computed over a full window are forwarded.
//
// Ports
//   i_CLK           sole clock, rising edge
//   i_RESET         synchronous reset, active low
//   i_smp_VALID     source presents a sample
//   i_smp_DATA      sample value
//   o_smp_READY     sample accepted this cycle when VALID is also high
//   i_MODE_SEL      00 avg, 01 std dev, 10 alternate per accept, 11 = 00
//   i_FLUSH         single-cycle request to clear the engine window
//   o_eng_RESET     active-high engine reset
//   o_eng_ENABLE    engine sample strobe
//   o_eng_MODE      0 avg, 1 std dev
//   o_eng_DATA      sample to the engine
//   i_eng_RESULT    engine result, LATENCY cycles after its sample
//   o_rsp_VALID     one-cycle result strobe
//   o_rsp_MODE      mode that produced o_rsp_RESULT
//   o_rsp_RESULT    captured engine result
//   o_WARM          window holds WINDOW samples since the last flush
module mote_engine_sequencer #(
  parameter int DATA_W  = 12,
  parameter int WINDOW  = 16,
  parameter int LATENCY = 4
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic              i_smp_VALID,
  input  logic [DATA_W-1:0] i_smp_DATA,
  output logic              o_smp_READY,
  input  logic [1:0]        i_MODE_SEL,
  input  logic              i_FLUSH,
  output logic              o_eng_RESET,
  output logic              o_eng_ENABLE,
  output logic              o_eng_MODE,
  output logic [DATA_W-1:0] o_eng_DATA,
  input  logic [DATA_W-1:0] i_eng_RESULT,
  output logic              o_rsp_VALID,
  output logic              o_rsp_MODE,
  output logic [DATA_W-1:0] o_rsp_RESULT,
  output logic              o_WARM
);

  localparam int CNT_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   fill_cnt_reg;
  logic               alt_reg;
  logic               rsp_valid_reg;
  logic               rsp_mode_reg;
  logic [DATA_W-1:0]  rsp_result_reg;

  logic               ready;
  logic               accept;
  logic               accept_mode;
  logic               last_fill;
  logic               tag_warm;
  logic [2:0]         tag_in;     // {valid, mode, warm}
  logic [2:0]         tap;
  logic               pipe_clear;
  logic               tap_fire;

  assign ready     = i_RESET && (state_reg != ST_FLUSH) && !i_FLUSH;
  assign accept    = i_smp_VALID && ready;
  assign last_fill = (state_reg == ST_FILL) && (fill_cnt_reg == CNT_W'(WINDOW - 1));
  // A sample is warm if it completes the window or arrives after it is full.
  assign tag_warm  = (state_reg == ST_RUN) || last_fill;

  always_comb begin
    accept_mode = 1'b0;
    case (i_MODE_SEL)
      2'b01:   accept_mode = 1'b1;
      2'b10:   accept_mode = alt_reg;
      default: accept_mode = 1'b0;
    endcase
  end

  assign tag_in = accept ? {1'b1, accept_mode, tag_warm} : 3'b000;

  // Flush request, flush state and reset all drop every in-flight tag.
  assign pipe_clear = !i_RESET || i_FLUSH || (state_reg == ST_FLUSH);

  // Tag pipeline, one register per engine latency stage.
  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_pipe
      logic [2:0] stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge i_CLK) begin
          if (pipe_clear) stage_reg <= 3'b000;
          else            stage_reg <= tag_in;
        end
      end else begin : g_body
        always_ff @(posedge i_CLK) begin
          if (pipe_clear) stage_reg <= 3'b000;
          else            stage_reg <= g_pipe[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign tap      = g_pipe[LATENCY-1].stage_reg;
  // A result being captured in the same cycle as a flush request is in flight too.
  assign tap_fire = tap[2] && tap[0] && !i_FLUSH;

  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      state_reg      <= ST_FLUSH;
      fill_cnt_reg   <= '0;
      alt_reg        <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_mode_reg   <= 1'b0;
      rsp_result_reg <= '0;
    end else begin
      rsp_valid_reg <= tap_fire;
      if (tap_fire) begin
        rsp_mode_reg   <= tap[1];
        rsp_result_reg <= i_eng_RESULT;
      end

      // Alternate mode only advances on samples actually taken in that mode.
      if (accept && (i_MODE_SEL == 2'b10)) alt_reg <= ~alt_reg;

      if (i_FLUSH) begin
        state_reg <= ST_FLUSH;
      end else begin
        case (state_reg)
          ST_FLUSH: begin
            fill_cnt_reg <= '0;
            alt_reg      <= 1'b0;
            state_reg    <= ST_FILL;
          end
          ST_FILL: begin
            if (accept) begin
              fill_cnt_reg <= fill_cnt_reg + 1'b1;
              if (last_fill) state_reg <= ST_RUN;
            end
          end
          ST_RUN:  state_reg <= ST_RUN;
          default: state_reg <= ST_FLUSH;
        endcase
      end
    end
  end

  assign o_smp_READY  = ready;
  assign o_eng_RESET  = !i_RESET || (state_reg == ST_FLUSH);
  assign o_eng_ENABLE = accept;
  assign o_eng_MODE   = accept && accept_mode;
  assign o_eng_DATA   = accept ? i_smp_DATA : '0;
  assign o_rsp_VALID  = i_RESET && rsp_valid_reg;
  assign o_rsp_MODE   = i_RESET && rsp_mode_reg;
  assign o_rsp_RESULT = i_RESET ? rsp_result_reg : '0;
  assign o_WARM       = i_RESET && (state_reg == ST_RUN);

endmodule

// File: tb/tb_mote_engine_sequencer.sv
module tb_mote_engine_sequencer;

  localparam int DATA_W  = 12;
  localparam int WINDOW  = 16;
  localparam int LATENCY = 4;

  logic              i_CLK = 1'b0;
  logic              i_RESET = 1'b0;
  logic              i_smp_VALID = 1'b0;
  logic [DATA_W-1:0] i_smp_DATA = '0;
  logic              o_smp_READY;
  logic [1:0]        i_MODE_SEL = 2'b00;
  logic              i_FLUSH = 1'b0;
  logic              o_eng_RESET;
  logic              o_eng_ENABLE;
  logic              o_eng_MODE;
  logic [DATA_W-1:0] o_eng_DATA;
  logic [DATA_W-1:0] i_eng_RESULT;
  logic              o_rsp_VALID;
  logic              o_rsp_MODE;
  logic [DATA_W-1:0] o_rsp_RESULT;
  logic              o_WARM;

  mote_engine_sequencer #(.DATA_W(DATA_W), .WINDOW(WINDOW), .LATENCY(LATENCY)) dut (
    .i_CLK(i_CLK), .i_RESET(i_RESET),
    .i_smp_VALID(i_smp_VALID), .i_smp_DATA(i_smp_DATA), .o_smp_READY(o_smp_READY),
    .i_MODE_SEL(i_MODE_SEL), .i_FLUSH(i_FLUSH),
    .o_eng_RESET(o_eng_RESET), .o_eng_ENABLE(o_eng_ENABLE), .o_eng_MODE(o_eng_MODE),
    .o_eng_DATA(o_eng_DATA), .i_eng_RESULT(i_eng_RESULT),
    .o_rsp_VALID(o_rsp_VALID), .o_rsp_MODE(o_rsp_MODE), .o_rsp_RESULT(o_rsp_RESULT),
    .o_WARM(o_WARM)
  );

  always #5 i_CLK = ~i_CLK;

  int cyc = 0;
  always @(posedge i_CLK) cyc <= cyc + 1;

  // Engine stand-in: a fixed-latency function of what was strobed into it.
  function automatic logic [DATA_W-1:0] eng_f(input logic [DATA_W-1:0] d, input bit m);
    return m ? (d ^ 12'h5A5) : d;
  endfunction

  logic [DATA_W+1:0] eng_pipe [LATENCY];
  always @(posedge i_CLK) begin
    eng_pipe[0] <= {o_eng_ENABLE, o_eng_MODE, o_eng_DATA};
    for (int k = 1; k < LATENCY; k++) eng_pipe[k] <= eng_pipe[k-1];
  end
  assign i_eng_RESULT = eng_pipe[LATENCY-1][DATA_W+1] ?
                        eng_f(eng_pipe[LATENCY-1][DATA_W-1:0], eng_pipe[LATENCY-1][DATA_W]) :
                        12'hBAD;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int                due;
    bit                mode;
    logic [DATA_W-1:0] res;
  } exp_t;
  exp_t sbq[$];

  // Reference model state: what the sequencer should have seen since flush.
  bit m_blocked = 1'b1;
  int m_count   = 0;
  bit m_alt     = 1'b0;

  task automatic drop_from(input int first_due);
    exp_t keep[$];
    foreach (sbq[i]) if (sbq[i].due < first_due) keep.push_back(sbq[i]);
    sbq = keep;
  endtask

  task automatic step(input bit rst_n, input bit v, input logic [DATA_W-1:0] d,
                      input logic [1:0] sel, input bit fl);
    bit exp_rdy, acc, md;
    @(posedge i_CLK); #1;
    i_RESET = rst_n; i_smp_VALID = v; i_smp_DATA = d; i_MODE_SEL = sel; i_FLUSH = fl;
    #3;
    if (!rst_n) begin
      chk("rst_eng_reset", int'(o_eng_RESET), 1);
      chk("rst_ready", int'(o_smp_READY), 0);
      chk("rst_enable", int'(o_eng_ENABLE), 0);
      chk("rst_warm", int'(o_WARM), 0);
      chk("rst_rsp_valid", int'(o_rsp_VALID), 0);
      drop_from(cyc);
      m_blocked = 1'b1; m_count = 0; m_alt = 1'b0;
    end else begin
      exp_rdy = !m_blocked && !fl;
      chk("ready", int'(o_smp_READY), int'(exp_rdy));
      chk("eng_reset", int'(o_eng_RESET), int'(m_blocked));
      chk("warm", int'(o_WARM), int'(m_count >= WINDOW));
      acc = v && exp_rdy;
      chk("eng_enable", int'(o_eng_ENABLE), int'(acc));
      if (acc) begin
        md = (sel == 2'b01) ? 1'b1 : (sel == 2'b10) ? m_alt : 1'b0;
        chk("eng_mode", int'(o_eng_MODE), int'(md));
        chk("eng_data", int'(o_eng_DATA), int'(d));
        if (sel == 2'b10) m_alt = ~m_alt;
        if (m_count < WINDOW) m_count++;
        if (m_count >= WINDOW) sbq.push_back('{due: cyc + LATENCY + 1, mode: md, res: eng_f(d, md)});
      end
      if (fl) begin
        drop_from(cyc + 1);
        m_blocked = 1'b1; m_count = 0; m_alt = 1'b0;
      end else begin
        m_blocked = 1'b0;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(posedge i_CLK) begin
    #4;
    if (o_rsp_VALID) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_cycle", cyc, e.due);
        chk("rsp_mode", int'(o_rsp_MODE), int'(e.mode));
        chk("rsp_result", int'(o_rsp_RESULT), int'(e.res));
      end
    end
  end

  initial begin
    // Reset held low three cycles, then released.
    for (int i = 0; i < 3; i++) step(0, 0, '0, 2'b00, 0);
    step(1, 1, 12'h111, 2'b00, 0);   // still in FLUSH: not accepted
    // Average mode, samples 1..16 back to back; only the 16th is warm.
    for (int i = 1; i <= 16; i++) step(1, 1, DATA_W'(i), 2'b00, 0);
    for (int i = 0; i < 6; i++) step(1, 0, '0, 2'b00, 0);
    // Alternate mode, 20 continuous samples.
    for (int i = 0; i < 20; i++) step(1, 1, DATA_W'($urandom), 2'b10, 0);
    // Gapped alternate stream: a sample every third cycle.
    for (int i = 0; i < 30; i++) step(1, (i % 3) == 0, DATA_W'($urandom), 2'b10, 0);
    // Three samples in flight, then flush (a sample offered alongside is refused).
    for (int i = 0; i < 3; i++) step(1, 1, DATA_W'($urandom), 2'b01, 0);
    step(1, 1, 12'h777, 2'b01, 1);
    for (int i = 0; i < 22; i++) step(1, 1, DATA_W'($urandom), 2'b11, 0);
    // Extreme data values.
    for (int i = 0; i < 8; i++) step(1, 1, (i % 2) ? 12'h000 : 12'hFFF, 2'(i % 4), 0);
    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step(1, $urandom_range(0, 3) != 0, DATA_W'($urandom), 2'($urandom_range(0, 3)),
           $urandom_range(0, 59) == 0);
    // Reset mid-stream with samples in flight.
    for (int i = 0; i < 3; i++) step(1, 1, DATA_W'($urandom), 2'b00, 0);
    step(0, 1, 12'h123, 2'b00, 0);
    step(0, 0, '0, 2'b00, 0);
    for (int i = 0; i < 40; i++) step(1, 1, DATA_W'($urandom), 2'b10, 0);
    for (int i = 0; i < 10; i++) step(1, 0, '0, 2'b00, 0);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mote_engine_sequencer.md
MOTE_ENGINE_SEQUENCER -- requirements
Module: mote_engine_sequencer

Interface
REQ-001 Parameter DATA_W, default 12, sample and result width.
REQ-002 Parameter WINDOW, default 16, engine window depth in samples.
REQ-003 Parameter LATENCY, default 4, engine cycles from ENABLE-qualified sample to its result.
REQ-004 The design SHALL use one clock and synchronous, active-low reset.
REQ-005 i_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-006 i_RESET  in  1  synchronous reset; asserted when low, sampled on i_CLK.
REQ-007 i_smp_VALID  in  1  source presents a sample.
REQ-008 i_smp_DATA  in  DATA_W  sample value.
REQ-009 o_smp_READY  out  1  sequencer accepts a sample this cycle.
REQ-010 i_MODE_SEL  in  2  00 average, 01 std dev, 10 alternate per accepted sample, 11 reserved (treated as 00).
REQ-011 i_FLUSH  in  1  single-cycle request to clear the engine window.
REQ-012 o_eng_RESET  out  1  active-high reset to the engine.
REQ-013 o_eng_ENABLE  out  1  engine sample strobe.
REQ-014 o_eng_MODE  out  1  0 average, 1 std dev.
REQ-015 o_eng_DATA  out  DATA_W  sample to the engine.
REQ-016 i_eng_RESULT  in  DATA_W  engine result.
REQ-017 o_rsp_VALID  out  1  one-cycle strobe; result valid.
REQ-018 o_rsp_MODE  out  1  mode that produced o_rsp_RESULT.
REQ-019 o_rsp_RESULT  out  DATA_W  captured engine result.
REQ-020 o_WARM  out  1  window holds WINDOW samples since the last flush.

Function
REQ-021 FSM states SHALL be FLUSH, FILL, RUN.
REQ-022 FLUSH SHALL last exactly one cycle: o_eng_RESET=1, o_smp_READY=0, fill counter cleared, alternate toggle cleared to 0, tag pipeline cleared; next state FILL.
REQ-023 In FILL and RUN, o_smp_READY SHALL be 1 unless i_FLUSH is high that cycle.
REQ-024 An accepted sample (i_smp_VALID and o_smp_READY) SHALL drive o_eng_ENABLE=1, o_eng_DATA=i_smp_DATA, and o_eng_MODE per i_MODE_SEL in the same cycle; otherwise o_eng_ENABLE=0.
REQ-025 In alternate mode, the first accepted sample after flush uses mode 0, and each later accepted sample toggles the mode; idle cycles do not toggle it.
REQ-026 The fill counter SHALL increment per accepted sample in FILL; on the WINDOWth acceptance the state SHALL become RUN and the counter SHALL saturate.
REQ-027 Each accepted sample SHALL push a tag {valid, mode, warm}, where warm=1 if that sample completes or follows a full window, into a LATENCY-deep shift pipeline; non-accept cycles push valid=0.
REQ-028 When the pipeline output tag has valid=1 and warm=1, the sequencer SHALL register i_eng_RESULT into o_rsp_RESULT, set o_rsp_MODE to the tag mode, and pulse o_rsp_VALID for one cycle, LATENCY+1 cycles after acceptance.
REQ-029 Results with warm=0 SHALL be discarded (no o_rsp_VALID).
REQ-030 i_FLUSH in any state SHALL enter FLUSH next cycle; a sample offered with i_FLUSH is not accepted; in-flight tags are dropped.
REQ-031 Back-to-back accepts SHALL be sustained at 1 sample/cycle; no source-side stall in FILL or RUN.
REQ-032 o_WARM SHALL equal (state==RUN).

Reset
REQ-033 While i_RESET=0, all outputs SHALL be 0 except o_eng_RESET=1; on release the FSM SHALL enter FLUSH, then FILL.
REQ-034 Reset asserted mid-stream SHALL discard all in-flight tags; no o_rsp_VALID for pre-reset samples.

Verification
REQ-035 Reset low 3 cycles then high: o_eng_RESET=1 through the first post-reset cycle; o_smp_READY=1 from the second cycle; o_WARM=0.
REQ-036 MODE_SEL=00, samples 1..16 back-to-back: no o_rsp_VALID for samples 1-15; o_WARM=1 after the 16th accept; the 16th sample's result appears 5 cycles after its accept with mode 0.
REQ-037 MODE_SEL=10, 20 continuous samples after warm-up: o_eng_MODE toggles 0,1,0,... and o_rsp_MODE follows the same sequence delayed by 5 cycles.
REQ-038 Gapped stream (valid every 3rd cycle) in RUN: one o_rsp_VALID per sample, each 5 cycles after its accept, and the alternate mode does not advance on idle cycles.
REQ-039 i_FLUSH pulsed in RUN with 3 samples in flight: no o_rsp_VALID for those samples; o_eng_RESET=1 for one cycle; o_WARM=0; 16 new samples are required before the next response.
REQ-040 Samples of 0xFFF and 0x000: o_eng_DATA equals the sample bit-exactly; o_rsp_RESULT equals i_eng_RESULT sampled at the pipeline tap.
